// File: rtl/gactx_dir_bank_packer.sv
// Packs DIR_BITS traceback symbols into W-bit words and stores each tile in one
// of NUM_BANKS round-robin banks, which the host drains in order.
module gactx_dir_bank_packer #(
  parameter int DIR_BITS      = 2,
  parameter int SYMS_PER_WORD = 32,
  parameter int ADDR_W        = 14,
  parameter int NUM_BANKS     = 2,
  localparam int W      = DIR_BITS * SYMS_PER_WORD,
  localparam int BANK_W = $clog2(NUM_BANKS),
  localparam int IDX_W  = $clog2(SYMS_PER_WORD),
  localparam int SC_W   = ADDR_W + IDX_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                in_ready,
  input  logic                tile_start,
  input  logic                dir_valid,
  input  logic [DIR_BITS-1:0] dir,
  input  logic                tile_end,
  output logic                rd_valid,
  output logic [BANK_W-1:0]   rd_bank,
  output logic [ADDR_W:0]     rd_word_count,
  output logic [SC_W-1:0]     rd_sym_count,
  output logic                rd_overflow,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [W-1:0]        rd_data,
  input  logic                rd_release
);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_FLUSH} wr_state_t;
  typedef enum logic [1:0] {B_FREE, B_FILLING, B_COMPLETE} bank_state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS_PER_WORD - 1);
  localparam logic [ADDR_W:0]  FULL_WC  = {1'b1, {ADDR_W{1'b0}}};

  wr_state_t   state, state_next;
  bank_state_t bank_st [NUM_BANKS];
  logic [ADDR_W:0]   bank_wc [NUM_BANKS];
  logic [SC_W-1:0]   bank_sc [NUM_BANKS];
  logic              bank_ov [NUM_BANKS];
  logic [BANK_W-1:0] wr_ptr, rd_ptr;

  logic [IDX_W-1:0] sym_idx;
  logic [ADDR_W:0]  word_count;
  logic [SC_W-1:0]  sym_count;
  logic             overflow;
  logic [W-1:0]     acc, acc_next;

  logic [W-1:0] mem [NUM_BANKS][2**ADDR_W];

  logic start, accept, flush, full, word_done, flush_wr, mem_we, release_ok;
  logic [W-1:0]    mem_wdata;
  logic [ADDR_W:0] wc_final;

  always_ff @(posedge clk) begin
    if (rst) state <= W_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    start      = 1'b0;
    accept     = 1'b0;
    flush      = 1'b0;
    case (state)
      W_IDLE: begin
        in_ready = (bank_st[wr_ptr] == B_FREE);
        if (tile_start && in_ready) begin
          start      = 1'b1;
          state_next = W_FILL;
        end
      end
      W_FILL: begin
        accept = dir_valid;
        if (tile_end) state_next = W_FLUSH;
      end
      W_FLUSH: begin
        flush      = 1'b1;
        state_next = W_IDLE;
      end
      default: state_next = W_IDLE;
    endcase
  end

  // The accumulator is treated as empty whenever a new word begins.
  always_comb begin
    acc_next = (sym_idx == '0) ? '0 : acc;
    acc_next[DIR_BITS*sym_idx +: DIR_BITS] = dir;
  end

  assign full       = (word_count == FULL_WC);
  assign word_done  = accept && !full && (sym_idx == LAST_IDX);
  assign flush_wr   = flush && (sym_idx != '0) && !overflow;
  assign mem_we     = word_done || flush_wr;
  assign mem_wdata  = flush ? acc : acc_next;
  assign wc_final   = word_count + {{ADDR_W{1'b0}}, flush_wr};
  assign release_ok = rd_release && (bank_st[rd_ptr] == B_COMPLETE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_idx    <= '0;
      word_count <= '0;
      sym_count  <= '0;
      overflow   <= 1'b0;
    end else if (start) begin
      sym_idx    <= '0;
      word_count <= '0;
      sym_count  <= '0;
      overflow   <= 1'b0;
    end else if (accept) begin
      sym_count <= sym_count + SC_W'(1);
      if (full) begin
        overflow <= 1'b1;
      end else if (sym_idx == LAST_IDX) begin
        sym_idx    <= '0;
        word_count <= word_count + (ADDR_W+1)'(1);
      end else begin
        sym_idx <= sym_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !full) acc <= acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_st[b] <= B_FREE;
        bank_wc[b] <= '0;
        bank_sc[b] <= '0;
        bank_ov[b] <= 1'b0;
      end
    end else begin
      if (start) bank_st[wr_ptr] <= B_FILLING;
      if (flush) begin
        bank_st[wr_ptr] <= B_COMPLETE;
        bank_wc[wr_ptr] <= wc_final;
        bank_sc[wr_ptr] <= sym_count;
        bank_ov[wr_ptr] <= overflow;
        wr_ptr          <= wr_ptr + BANK_W'(1);
      end
      if (release_ok) begin
        bank_st[rd_ptr] <= B_FREE;
        rd_ptr          <= rd_ptr + BANK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr][word_count[ADDR_W-1:0]] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_ptr][rd_addr];
  end

  assign rd_valid      = (bank_st[rd_ptr] == B_COMPLETE);
  assign rd_bank       = rd_ptr;
  assign rd_word_count = bank_wc[rd_ptr];
  assign rd_sym_count  = bank_sc[rd_ptr];
  assign rd_overflow   = bank_ov[rd_ptr];

endmodule

// File: tb/tb_gactx_dir_bank_packer.sv
// Directed bench: default instance for packing, ping-pong, coincident end, reset
// and empty tiles; a shallow instance for the overflow path.
module tb_gactx_dir_bank_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_ready, tile_start, dir_valid, tile_end, rd_valid, rd_overflow, rd_release;
  logic [1:0]  dir;
  logic [0:0]  rd_bank;
  logic [14:0] rd_word_count;
  logic [19:0] rd_sym_count;
  logic [13:0] rd_addr;
  logic [63:0] rd_data;

  logic        s_in_ready, s_tile_start, s_dir_valid, s_tile_end, s_rd_valid, s_rd_overflow, s_rd_release;
  logic [1:0]  s_dir;
  logic [0:0]  s_rd_bank;
  logic [2:0]  s_rd_word_count;
  logic [7:0]  s_rd_sym_count;
  logic [1:0]  s_rd_addr;
  logic [63:0] s_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  gactx_dir_bank_packer dut (
    .clk(clk), .rst(rst), .in_ready(in_ready), .tile_start(tile_start),
    .dir_valid(dir_valid), .dir(dir), .tile_end(tile_end), .rd_valid(rd_valid),
    .rd_bank(rd_bank), .rd_word_count(rd_word_count), .rd_sym_count(rd_sym_count),
    .rd_overflow(rd_overflow), .rd_addr(rd_addr), .rd_data(rd_data), .rd_release(rd_release)
  );

  gactx_dir_bank_packer #(.ADDR_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_ready(s_in_ready), .tile_start(s_tile_start),
    .dir_valid(s_dir_valid), .dir(s_dir), .tile_end(s_tile_end), .rd_valid(s_rd_valid),
    .rd_bank(s_rd_bank), .rd_word_count(s_rd_word_count), .rd_sym_count(s_rd_sym_count),
    .rd_overflow(s_rd_overflow), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_release(s_rd_release)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic send_mod4(input int n);
    for (int i = 0; i < n; i++) begin
      dir_valid = 1'b1;
      dir = 2'(i % 4);
      tick();
    end
    dir_valid = 1'b0;
  endtask

  task automatic send_const(input int n, input logic [1:0] v);
    for (int i = 0; i < n; i++) begin
      dir_valid = 1'b1;
      dir = v;
      tick();
    end
    dir_valid = 1'b0;
  endtask

  task automatic pulse_start();
    tile_start = 1'b1;
    tick();
    tile_start = 1'b0;
  endtask

  task automatic pulse_end();
    tile_end = 1'b1;
    tick();
    tile_end = 1'b0;
  endtask

  task automatic pulse_release();
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
  endtask

  initial begin
    tile_start = 0; dir_valid = 0; dir = 0; tile_end = 0; rd_release = 0; rd_addr = 0;
    s_tile_start = 0; s_dir_valid = 0; s_dir = 0; s_tile_end = 0; s_rd_release = 0; s_rd_addr = 0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_bank", 64'(rd_bank), 64'd0);
    check("rst_wc", 64'(rd_word_count), 64'd0);
    check("rst_sc", 64'(rd_sym_count), 64'd0);
    check("rst_ov", 64'(rd_overflow), 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    check("rst_s_in_ready", 64'(s_in_ready), 64'd1);

    // 70 symbols, dir = i mod 4, into bank 0
    pulse_start();
    check("fill_in_ready", 64'(in_ready), 64'd0);
    send_mod4(70);
    pulse_end();
    check("t1_valid_1edge", 64'(rd_valid), 64'd0);
    tick();
    check("t1_valid_2edge", 64'(rd_valid), 64'd1);
    check("t1_bank", 64'(rd_bank), 64'd0);
    check("t1_wc", 64'(rd_word_count), 64'd3);
    check("t1_sc", 64'(rd_sym_count), 64'd70);
    check("t1_ov", 64'(rd_overflow), 64'd0);
    rd_addr = 14'd0; tick();
    check("t1_word0", rd_data, 64'hE4E4E4E4E4E4E4E4);
    rd_addr = 14'd1; tick();
    check("t1_word1", rd_data, 64'hE4E4E4E4E4E4E4E4);
    rd_addr = 14'd2; tick();
    check("t1_word2", rd_data, 64'h00000000000004E4);

    // ping-pong: tile B into bank 1 while bank 0 is held
    check("pp_in_ready_b", 64'(in_ready), 64'd1);
    pulse_start();
    send_const(32, 2'd3);
    pulse_end();
    tick();
    check("pp_in_ready_full", 64'(in_ready), 64'd0);
    check("pp_still_bank0", 64'(rd_bank), 64'd0);
    pulse_start();
    check("pp_start_ignored", 64'(in_ready), 64'd0);
    rd_release = 1'b1;
    tile_start = 1'b1;
    #1;
    check("pp_ready_not_comb", 64'(in_ready), 64'd0);
    tick();
    rd_release = 1'b0;
    tile_start = 1'b0;
    check("pp_ready_next", 64'(in_ready), 64'd1);
    check("pp_rd_bank1", 64'(rd_bank), 64'd1);
    check("pp_valid_b", 64'(rd_valid), 64'd1);
    check("pp_wc_b", 64'(rd_word_count), 64'd1);
    check("pp_sc_b", 64'(rd_sym_count), 64'd32);
    rd_addr = 14'd0; tick();
    check("pp_word_b", rd_data, 64'hFFFFFFFFFFFFFFFF);

    // tile C into bank 0: 31 symbols then the 32nd together with tile_end
    pulse_start();
    send_const(31, 2'd1);
    dir_valid = 1'b1; dir = 2'd2; tile_end = 1'b1;
    tick();
    dir_valid = 1'b0; tile_end = 1'b0;
    tick();
    pulse_release();
    check("co_bank", 64'(rd_bank), 64'd0);
    check("co_valid", 64'(rd_valid), 64'd1);
    check("co_wc", 64'(rd_word_count), 64'd1);
    check("co_sc", 64'(rd_sym_count), 64'd32);
    rd_addr = 14'd0; tick();
    check("co_word", rd_data, 64'h9555555555555555);

    // reset while filling bank 0 with bank 1 complete
    pulse_release();
    pulse_start();
    send_const(5, 2'd2);
    pulse_end();
    tick();
    check("mr_valid_b1", 64'(rd_valid), 64'd1);
    check("mr_bank_b1", 64'(rd_bank), 64'd1);
    pulse_start();
    send_const(3, 2'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_in_ready", 64'(in_ready), 64'd1);
    check("mr_rd_valid", 64'(rd_valid), 64'd0);
    check("mr_rd_bank", 64'(rd_bank), 64'd0);
    check("mr_wc", 64'(rd_word_count), 64'd0);
    check("mr_sc", 64'(rd_sym_count), 64'd0);
    check("mr_rd_data", rd_data, 64'd0);

    // spurious release, then a zero-symbol tile in bank 0
    pulse_release();
    check("sp_rd_bank", 64'(rd_bank), 64'd0);
    check("sp_rd_valid", 64'(rd_valid), 64'd0);
    pulse_start();
    pulse_end();
    check("z_valid_1edge", 64'(rd_valid), 64'd0);
    tick();
    check("z_valid_2edge", 64'(rd_valid), 64'd1);
    check("z_bank", 64'(rd_bank), 64'd0);
    check("z_wc", 64'(rd_word_count), 64'd0);
    check("z_sc", 64'(rd_sym_count), 64'd0);
    check("z_ov", 64'(rd_overflow), 64'd0);
    check("z_in_ready", 64'(in_ready), 64'd1);

    // shallow instance: 130 symbols into a 4-word bank
    s_tile_start = 1'b1; tick(); s_tile_start = 1'b0;
    for (int i = 0; i < 130; i++) begin
      s_dir_valid = 1'b1;
      s_dir = 2'(i % 4);
      tick();
    end
    s_dir_valid = 1'b0;
    s_tile_end = 1'b1; tick(); s_tile_end = 1'b0;
    tick();
    check("ov_valid", 64'(s_rd_valid), 64'd1);
    check("ov_wc", 64'(s_rd_word_count), 64'd4);
    check("ov_sc", 64'(s_rd_sym_count), 64'd130);
    check("ov_flag", 64'(s_rd_overflow), 64'd1);
    s_rd_addr = 2'd3; tick();
    check("ov_word3", s_rd_data, 64'hE4E4E4E4E4E4E4E4);
    s_rd_addr = 2'd0; tick();
    check("ov_word0", s_rd_data, 64'hE4E4E4E4E4E4E4E4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gactx_dir_bank_packer.md
Name: gactx_dir_bank_packer

Overview:
- Parametrised successor to the single-buffer traceback-direction packing and dir-BRAM logic in the GACTX tile wrapper.
- Packs DIR_BITS-wide traceback symbols from the systolic array into memory words.
- Stores each tile in one of NUM_BANKS banks, so the array can start the next tile while the host drains earlier tiles.
- Sits between the array's dir/dir_valid/done outputs and the host read interface.

Parameters:
- DIR_BITS, 2: width of one direction symbol.
- SYMS_PER_WORD, 32: symbols packed per memory word. Word width is W = DIR_BITS*SYMS_PER_WORD.
- ADDR_W, 14: word address width per bank. Bank depth is 2^ADDR_W.
- NUM_BANKS, 2: number of banks. Must be a power of 2, ≥2. BANK_W = clog2(NUM_BANKS).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_ready  out  1  a tile may be started this cycle
- tile_start  in  1  pulse; opens a new tile in the next write bank
- dir_valid  in  1  dir carries a symbol
- dir  in  DIR_BITS  traceback symbol
- tile_end  in  1  pulse; closes the current tile
- rd_valid  out  1  oldest completed bank is available to the host
- rd_bank  out  BANK_W  index of that bank
- rd_word_count  out  ADDR_W+1  words written into that bank
- rd_sym_count  out  ADDR_W+clog2(SYMS_PER_WORD)+1  symbols received for that tile, including dropped symbols
- rd_overflow  out  1  symbols were dropped in that tile
- rd_addr  in  ADDR_W  word address within rd_bank
- rd_data  out  W  word at rd_addr
- rd_release  in  1  pulse; frees the rd_bank bank

Behaviour:
- Reset values:
  - in_ready = 1; rd_valid = 0; rd_bank = 0; all counts = 0; rd_overflow = 0; rd_data = 0.
  - All banks FREE; write and read pointers = 0.
  - Memory contents are not cleared.
- Bank states: FREE → FILLING → COMPLETE → FREE.
  - Banks are allocated round-robin by wr_ptr and drained in order by rd_ptr, modulo NUM_BANKS.
- Write FSM states: W_IDLE, W_FILL, W_FLUSH.
  - in_ready = (W_IDLE) && bank[wr_ptr] == FREE.
  - W_IDLE + tile_start + in_ready → W_FILL. Bank[wr_ptr] becomes FILLING; sym_idx, word_count, sym_count and overflow are zeroed.
  - tile_start while in_ready = 0 is ignored, with no state change.
- Packing in W_FILL, on dir_valid:
  - Symbol k of a word occupies bits [DIR_BITS*k +: DIR_BITS]. Symbol 0 is the LSB.
  - Unused high bits of a partial word are 0; the accumulator is cleared when a new word begins.
  - sym_count increments on every accepted symbol.
  - When sym_idx reaches SYMS_PER_WORD-1, the word is written at address word_count on the next edge; word_count increments and sym_idx returns to 0. Back-to-back dir_valid is sustained at 1 symbol per cycle.
- Overflow:
  - If word_count == 2^ADDR_W, further symbols are counted in sym_count but not stored.
  - The bank's overflow flag is set (sticky for that tile).
- Tile end:
  - tile_end in W_FILL → W_FLUSH.
  - If dir_valid and tile_end are asserted in the same cycle, the symbol is packed first.
  - In W_FLUSH: if sym_idx > 0 and no overflow, the partial word is written and word_count increments.
  - The bank then becomes COMPLETE with its counts latched, wr_ptr increments, and the FSM returns to W_IDLE.
  - Latency from tile_end to the bank being COMPLETE is 2 edges.
- dir_valid or tile_end outside W_FILL is ignored.
- Read side:
  - rd_valid = (bank[rd_ptr] == COMPLETE). rd_bank = rd_ptr.
  - Counts and overflow are those of bank rd_ptr.
  - rd_data is registered: rd_data on cycle n+1 is the word at (rd_bank, rd_addr) on cycle n.
  - rd_release while rd_valid: bank becomes FREE and rd_ptr increments. rd_release while rd_valid = 0 is ignored.
- Read/write concurrency:
  - The read port and write port are independent; a read from a COMPLETE bank while another bank fills is allowed.
  - rd_release and tile_start in the same cycle: if the freed bank is bank[wr_ptr], in_ready rises the following cycle (not combinationally).
- A zero-symbol tile (tile_start then tile_end) completes with word_count = 0 and sym_count = 0.

Test Plan:
- Defaults, 70 consecutive symbols (dir = i mod 4) then tile_end:
  - 3 words written; word 2 holds symbols 64..69 in bits [11:0], upper bits 0.
  - rd_word_count = 3, rd_sym_count = 70, rd_overflow = 0.
  - rd_data matches one cycle after each rd_addr.
- Ping-pong:
  - Fill tile A in bank 0 and do not release; tile B fills bank 1.
  - in_ready then drops and tile_start is ignored.
  - rd_release of bank 0 restores in_ready next cycle; tile C goes to bank 0.
- ADDR_W = 2, 130 symbols:
  - 4 words stored, rd_overflow = 1, rd_sym_count = 130, rd_word_count = 4.
- dir_valid coincident with tile_end after 31 symbols:
  - That 32nd symbol lands in bit [63:62]; exactly 1 word; no extra flush word.
- Reset asserted mid-W_FILL with bank 1 COMPLETE:
  - Next cycle in_ready = 1, rd_valid = 0, pointers = 0.
  - A new tile goes to bank 0.
- Zero-symbol tile:
  - rd_valid = 1 two edges after tile_end, with counts 0.
  - Spurious rd_release while rd_valid = 0 has no effect.
